// File: rtl/pwm_capture.sv
// pwm_capture: measures an external PWM waveform and recovers its 8-bit duty
// code, floor(high*256/period), in the same scale the PWM generator accepts.
// A line with no rising edge for TIMEOUT_MUL*NOM cycles is reported as stuck,
// with duty forced to 0 or 255 according to the held level.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   pwm_in     asynchronous PWM input (synchronized internally)
//   duty       recovered duty code, held between updates
//   duty_valid one-cycle pulse when duty/period/stuck are updated
//   period     last accepted period in clock cycles
//   stuck      no rising edge seen within the timeout
module pwm_capture #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int PWM_FREQ    = 20_000,
  parameter int TIMEOUT_MUL = 4,
  parameter int MIN_PERIOD  = 16,
  localparam int NOM  = CLK_FREQ / PWM_FREQ,
  localparam int TMAX = TIMEOUT_MUL * NOM,
  localparam int W    = $clog2(TMAX) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pwm_in,
  output logic [7:0]   duty,
  output logic         duty_valid,
  output logic [W-1:0] period,
  output logic         stuck
);

  localparam logic [W-1:0] TMAX_W = W'(TMAX);
  localparam logic [W-1:0] MIN_W  = W'(MIN_PERIOD);

  typedef enum logic [1:0] {SEEK, MEASURE, DIVIDE} state_t;

  state_t         state, nxt;
  logic           s1, sync, prev;
  logic [W-1:0]   per, hi, p_lat;
  logic [W:0]     rem, rem_sh, rem_nx;
  logic [7:0]     quo;
  logic [2:0]     cnt;
  logic           to_done;  // timeout already reported; cleared by the next rise
  logic           rise, accept, timeout, ge;

  assign rise    = sync & ~prev;
  assign accept  = (state == MEASURE) && rise && (per >= MIN_W);
  // A rise in the same cycle wins over the timeout.
  assign timeout = (per == TMAX_W) && !rise && !to_done && (state != DIVIDE);

  // One restoring-division step per cycle; rem < p_lat holds between steps,
  // so the doubled remainder always fits in W+1 bits.
  assign rem_sh = {rem[W-1:0], 1'b0};
  assign ge     = rem_sh >= {1'b0, p_lat};
  assign rem_nx = ge ? rem_sh - {1'b0, p_lat} : rem_sh;

  always_comb begin
    nxt = state;
    case (state)
      SEEK:    if (rise) nxt = MEASURE;
      MEASURE: if (accept) nxt = DIVIDE;
               else if (timeout) nxt = SEEK;
      DIVIDE:  if (cnt == 3'd7) nxt = MEASURE;
      default: nxt = SEEK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEEK;
    else        state <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0; sync <= 1'b0; prev <= 1'b0;
      per <= '0; hi <= '0; p_lat <= '0; rem <= '0; quo <= '0; cnt <= '0;
      to_done <= 1'b0;
      duty <= '0; duty_valid <= 1'b0; period <= '0; stuck <= 1'b0;
    end else begin
      s1   <= pwm_in;
      sync <= s1;
      prev <= sync;
      duty_valid <= 1'b0;

      // Counters restart on every rise (accepted or not) and saturate at TMAX.
      if (rise) begin
        per <= W'(1);
        hi  <= W'(sync);
      end else begin
        if (per != TMAX_W)         per <= per + W'(1);
        if (sync && hi != TMAX_W)  hi  <= hi + W'(1);
      end

      if (rise)         to_done <= 1'b0;
      else if (timeout) to_done <= 1'b1;

      if (accept) begin
        p_lat <= per;
        rem   <= {1'b0, hi};
        quo   <= '0;
        cnt   <= '0;
      end

      if (state == DIVIDE) begin
        rem <= rem_nx;
        quo <= {quo[6:0], ge};
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7) begin
          duty       <= {quo[6:0], ge};
          period     <= p_lat;
          duty_valid <= 1'b1;
          stuck      <= 1'b0;
        end
      end

      if (timeout) begin
        duty       <= {8{sync}};
        stuck      <= 1'b1;
        duty_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios plus random periods, checked
// against a rise-time based reference model of the measurement rules.
module tb_pwm_capture;

  localparam int TMAX = 10000;
  localparam int MINP = 16;
  localparam int LAT  = 11;  // drive-to-pulse: 2 sync stages + E+9

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm_in;
  logic [7:0]  duty;
  logic        duty_valid;
  logic [14:0] period;
  logic        stuck;

  pwm_capture dut (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .duty(duty), .duty_valid(duty_valid), .period(period), .stuck(stuck)
  );

  always #5 clk = ~clk;

  typedef struct {int t; int duty; int per; bit keep; bit stuck;} pulse_t;

  pulse_t expq[$];
  pulse_t gotq[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dbl = 0;
  logic last_dv = 1'b0;

  // reference model state (drive-time based)
  int last_rise, hsum;
  bit pv, seek, to_done;
  int m_duty, m_per;
  bit m_stuck;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (duty_valid === 1'b1) begin
      gotq.push_back('{cyc, int'(duty), int'(period), 1'b0, stuck});
      if (last_dv === 1'b1) dbl <= dbl + 1;
    end
    last_dv <= duty_valid;
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: a rise ends the running period; a gap of more than TMAX cycles
  // since the last rise reports the level held at the timeout point.
  task automatic mstep(bit v);
    int t, p;
    t = cyc;
    if (!to_done && (t - last_rise) == TMAX + 1) begin
      expq.push_back('{t + 2, pv ? 255 : 0, 0, 1'b1, 1'b1});
      seek = 1; to_done = 1;
    end
    if (v && !pv) begin
      if (!seek) begin
        p = t - last_rise;
        if (p >= MINP) expq.push_back('{t + LAT, (hsum * 256) / p, p, 1'b0, 1'b0});
      end
      seek = 0; to_done = 0; last_rise = t; hsum = 0;
    end
    hsum += int'(v);
    pv = v;
  endtask

  task automatic step(bit v);
    @(posedge clk); #1;
    pwm_in = v;
    mstep(v);
  endtask

  task automatic run(bit v, int n);
    repeat (n) step(v);
  endtask

  task automatic prd(int h, int l);
    run(1'b1, h);
    run(1'b0, l);
  endtask

  // Compare every pulse that is already due, then the held outputs.
  task automatic settle(string tag);
    int ne, ng;
    pulse_t e, g;
    ne = 0; ng = 0;
    foreach (expq[i]) if (expq[i].t < cyc) ne++;
    foreach (gotq[i]) if (gotq[i].t < cyc) ng++;
    chk({tag, "_npulse"}, ng, ne);
    while (ne > 0 && ng > 0) begin
      e = expq.pop_front(); g = gotq.pop_front();
      chk({tag, "_ptime"}, g.t, e.t);
      chk({tag, "_pduty"}, g.duty, e.duty);
      chk({tag, "_pperiod"}, g.per, e.keep ? m_per : e.per);
      chk({tag, "_pstuck"}, 32'(g.stuck), 32'(e.stuck));
      m_duty = e.duty;
      if (!e.keep) m_per = e.per;
      m_stuck = e.stuck;
      ne--; ng--;
    end
    while (ne > 0) begin e = expq.pop_front(); ne--; end
    while (ng > 0) begin g = gotq.pop_front(); ng--; end
    chk({tag, "_duty"}, duty, m_duty);
    chk({tag, "_period"}, period, m_per);
    chk({tag, "_stuck"}, stuck, 32'(m_stuck));
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst_n = 1'b1;
    pv = 0; seek = 1; to_done = 0; hsum = 0;
    last_rise = cyc - 2;
  endtask

  // Assert reset right now (just after an edge); pulses not yet visible vanish.
  task automatic do_reset(string tag, int n);
    pulse_t tmp[$];
    rst_n = 1'b0;
    pwm_in = 1'b0;
    foreach (expq[i]) if (expq[i].t < cyc) tmp.push_back(expq[i]);
    expq = tmp;
    settle({tag, "_pre"});
    m_duty = 0; m_per = 0; m_stuck = 0;
    @(negedge clk);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_stuck"}, stuck, 0);
    chk({tag, "_dv"}, duty_valid, 0);
    repeat (n) @(posedge clk);
    release_rst();
  endtask

  initial begin
    int p, h;
    rst_n = 1'b0;
    pwm_in = 1'b0;
    m_duty = 0; m_per = 0; m_stuck = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("rst_period", period, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_dv", duty_valid, 0);
    release_rst();

    // 1: 25% at nominal period
    repeat (4) prd(625, 1875);
    settle("t1");
    chk("t1_duty64", duty, 64);
    chk("t1_period2500", period, 2500);

    // 2: 50% then 2499/2500 (floors to 255)
    repeat (2) prd(1250, 1250);
    settle("t2a");
    chk("t2_duty128", duty, 128);
    repeat (2) prd(2499, 1);
    settle("t2b");
    chk("t2_duty255", duty, 255);

    // 3: 50% stream, then line stuck low
    repeat (2) prd(1250, 1250);
    run(1'b0, 10100);
    settle("t3");
    chk("t3_duty0", duty, 0);
    chk("t3_stuck", stuck, 1);
    chk("t3_period_kept", period, 2500);

    // 4: stuck high, then a 25% stream recovers
    run(1'b1, 10100);
    settle("t4a");
    chk("t4_duty255", duty, 255);
    chk("t4_stuck", stuck, 1);
    repeat (3) prd(625, 1875);
    settle("t4b");
    chk("t4_duty64", duty, 64);
    chk("t4_unstuck", stuck, 0);

    // 5: glitch rise 10 cycles after a rise
    run(1'b1, 5);
    run(1'b0, 5);
    run(1'b1, 20);
    settle("t5a");
    chk("t5_duty_held", duty, 64);
    run(1'b1, 595);
    run(1'b0, 1875);
    repeat (2) prd(625, 1875);
    settle("t5b");
    chk("t5_duty64", duty, 64);

    // 6: reset at E+4 while the divider is busy
    run(1'b1, 7);
    do_reset("t6rst", 4);
    run(1'b0, 20);
    settle("t6a");
    repeat (3) prd(625, 1875);
    settle("t6b");
    chk("t6_duty64", duty, 64);
    chk("t6_period", period, 2500);

    // random periods, including sub-MIN_PERIOD ones
    for (int i = 0; i < 20; i++) begin
      p = int'($urandom_range(800, 10));
      h = int'($urandom_range(p - 1, 1));
      prd(h, p - h);
    end
    run(1'b0, 30);
    settle("rnd");

    chk("no_back_to_back", dbl, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
